// File: rtl/w5300_socket_bank_conf.sv
// ---------------------------------------------------------------------------
// w5300_socket_bank_conf
//
// Brings up NUM_SOCK consecutive W5300 sockets. Each socket is configured
// with the same protocol. MODE 0 configures a TCP server, which is opened
// and then put into LISTEN. MODE 1 configures a UDP socket, which is only
// opened. Each socket uses port BASE_PORT+n.
//
// After each OPEN or LISTEN command the block polls Sn_SSR. A poll phase that
// runs TIMEOUT cycles without a match closes the socket and retries the whole
// configuration. After MAX_RETRY retries the socket is marked failed and the
// block moves on to the next socket.
//
// Bus encoding: addr = {wr, reg[9:0]}, where wr=1 is a write and wr=0 is a
// read. Socket n registers live at 0x200 + n*0x40. The offsets used are:
//   MR 0x00, CR 0x02, SSR 0x08, PORTR 0x0A, KPALVTR_PROTOR 0x1A.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   enable          start request, sampled only in Idle (needs op_state too)
//   op_state        bus-op completion strobe; rd_data valid in the same cycle
//   rd_data[15:0]   W5300 read data
//   addr[10:0]      {wr, register address}
//   wr_data[15:0]   write data, 0 for reads
//   done            high once the bank configuration has finished
//   ok_mask         per socket: reached its target state
//   fail_mask       per socket: retries exhausted
//
// Build option: define W5300_SOCK_KEEPALIVE_EN to insert a keep-alive write
// (Sn_KPALVTR_PROTOR = 0x0101) between SetPort and Open. This applies to
// TCP mode only.
// ---------------------------------------------------------------------------
module w5300_socket_bank_conf #(
    parameter int          NUM_SOCK  = 1,
    parameter int          MODE      = 0,
    parameter logic [15:0] BASE_PORT = 16'd7000,
    parameter logic [15:0] TIMEOUT   = 16'd100,
    parameter int          MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                op_state,
    input  logic [15:0]         rd_data,
    output logic [10:0]         addr,
    output logic [15:0]         wr_data,
    output logic                done,
    output logic [NUM_SOCK-1:0] ok_mask,
    output logic [NUM_SOCK-1:0] fail_mask
);
    localparam logic [3:0] S_IDLE        = 4'd0;
    localparam logic [3:0] S_SET_MODE    = 4'd1;
    localparam logic [3:0] S_SET_PORT    = 4'd2;
    localparam logic [3:0] S_SET_KA      = 4'd3;
    localparam logic [3:0] S_OPEN        = 4'd4;
    localparam logic [3:0] S_POLL_INIT   = 4'd5;
    localparam logic [3:0] S_LISTEN      = 4'd6;
    localparam logic [3:0] S_POLL_LISTEN = 4'd7;
    localparam logic [3:0] S_CLOSE       = 4'd8;
    localparam logic [3:0] S_NEXT_SOCK   = 4'd9;
    localparam logic [3:0] S_DONE        = 4'd10;

    localparam logic       BUS_WR = 1'b1;
    localparam logic       BUS_RD = 1'b0;

    localparam logic [5:0] OFF_MR    = 6'h00;
    localparam logic [5:0] OFF_CR    = 6'h02;
    localparam logic [5:0] OFF_SSR   = 6'h08;
    localparam logic [5:0] OFF_PORTR = 6'h0A;
    localparam logic [5:0] OFF_KPALV = 6'h1A;

    localparam logic [15:0] MR_VAL      = (MODE == 0) ? 16'h0001 : 16'h0002;
    localparam logic [7:0]  INIT_MATCH  = (MODE == 0) ? 8'h13 : 8'h22;
    localparam logic [7:0]  LISTEN_MATCH = 8'h14;
    localparam logic [3:0]  MAX_RETRY_C = 4'(MAX_RETRY);
    localparam logic [3:0]  NUM_SOCK_C  = 4'(NUM_SOCK);

`ifdef W5300_SOCK_KEEPALIVE_EN
    localparam logic KA_EN = (MODE == 0);
`else
    localparam logic KA_EN = 1'b0;
`endif

    logic [3:0]          state_q, state_d;
    logic [2:0]          idx_q, idx_d;
    logic [3:0]          retry_q, retry_d;
    logic [15:0]         timer_q, timer_d;
    logic [NUM_SOCK-1:0] ok_q, ok_d;
    logic [NUM_SOCK-1:0] fail_q, fail_d;
    logic [NUM_SOCK-1:0] sock_sel;
    logic [3:0]          idx_inc;
    logic                unused_rd_hi;

    // Only the status byte of Sn_SSR is of interest.
    assign unused_rd_hi = ^rd_data[15:8];

    // One-hot select of the socket currently being configured.
    for (genvar gi = 0; gi < NUM_SOCK; gi++) begin : g_sel
        assign sock_sel[gi] = (idx_q == 3'(gi));
    end

    assign idx_inc = {1'b0, idx_q} + 4'd1;

    function automatic logic [9:0] get_socket_n_reg(input logic [2:0] n, input logic [5:0] off);
        return 10'h200 + {1'b0, n, off};
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        timer_d = timer_q;
        ok_d    = ok_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (enable && op_state) begin
                    state_d = S_SET_MODE;
                    idx_d   = 3'd0;
                    retry_d = 4'd0;
                end
            end
            S_SET_MODE: if (op_state) state_d = S_SET_PORT;
            S_SET_PORT: if (op_state) state_d = KA_EN ? S_SET_KA : S_OPEN;
            S_SET_KA:   if (op_state) state_d = S_OPEN;
            S_OPEN: begin
                if (op_state) begin
                    state_d = S_POLL_INIT;
                    timer_d = 16'd0;
                end
            end
            S_POLL_INIT: begin
                timer_d = timer_q + 16'd1;
                // An expired timer wins over a match arriving in the same cycle.
                if (timer_q == TIMEOUT) begin
                    state_d = S_CLOSE;
                end else if (op_state && rd_data[7:0] == INIT_MATCH) begin
                    if (MODE == 0) begin
                        state_d = S_LISTEN;
                    end else begin
                        ok_d    = ok_q | sock_sel;
                        state_d = S_NEXT_SOCK;
                    end
                end
            end
            S_LISTEN: begin
                if (op_state) begin
                    state_d = S_POLL_LISTEN;
                    timer_d = 16'd0;
                end
            end
            S_POLL_LISTEN: begin
                timer_d = timer_q + 16'd1;
                if (timer_q == TIMEOUT) begin
                    state_d = S_CLOSE;
                end else if (op_state && rd_data[7:0] == LISTEN_MATCH) begin
                    ok_d    = ok_q | sock_sel;
                    state_d = S_NEXT_SOCK;
                end
            end
            S_CLOSE: begin
                if (op_state) begin
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + 4'd1;
                        state_d = S_SET_MODE;
                    end else begin
                        fail_d  = fail_q | sock_sel;
                        state_d = S_NEXT_SOCK;
                    end
                end
            end
            S_NEXT_SOCK: begin
                retry_d = 4'd0;
                if (idx_inc < NUM_SOCK_C) begin
                    idx_d   = idx_inc[2:0];
                    state_d = S_SET_MODE;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs depend only on the current state, so they stay stable
    // until the op completes.
    always_comb begin
        addr    = {BUS_RD, 10'h000};
        wr_data = 16'h0000;
        case (state_q)
            S_SET_MODE: begin
                addr    = {BUS_WR, get_socket_n_reg(idx_q, OFF_MR)};
                wr_data = MR_VAL;
            end
            S_SET_PORT: begin
                addr    = {BUS_WR, get_socket_n_reg(idx_q, OFF_PORTR)};
                wr_data = BASE_PORT + {13'd0, idx_q};
            end
            S_SET_KA: begin
                addr    = {BUS_WR, get_socket_n_reg(idx_q, OFF_KPALV)};
                wr_data = 16'h0101;
            end
            S_OPEN: begin
                addr    = {BUS_WR, get_socket_n_reg(idx_q, OFF_CR)};
                wr_data = 16'h0001;
            end
            S_LISTEN: begin
                addr    = {BUS_WR, get_socket_n_reg(idx_q, OFF_CR)};
                wr_data = 16'h0002;
            end
            S_CLOSE: begin
                addr    = {BUS_WR, get_socket_n_reg(idx_q, OFF_CR)};
                wr_data = 16'h0010;
            end
            S_POLL_INIT, S_POLL_LISTEN: begin
                addr    = {BUS_RD, get_socket_n_reg(idx_q, OFF_SSR)};
            end
            default: begin
                addr    = {BUS_RD, 10'h000};
                wr_data = 16'h0000;
            end
        endcase
    end

    assign done      = (state_q == S_DONE);
    assign ok_mask   = ok_q;
    assign fail_mask = fail_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= 3'd0;
            retry_q <= 4'd0;
            timer_q <= 16'd0;
            ok_q    <= '0;
            fail_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            timer_q <= timer_d;
            ok_q    <= ok_d;
            fail_q  <= fail_d;
        end
    end
endmodule

// File: tb/tb_w5300_socket_bank_conf.sv
// ---------------------------------------------------------------------------
// tb_w5300_socket_bank_conf
//
// Two configurations run side by side:
//   inst 0: TCP server, 3 sockets, port 7000.., TIMEOUT 100, MAX_RETRY 3
//   inst 1: UDP, 2 sockets, port 0xFFFF (wraps to 0x0000), TIMEOUT 12,
//           MAX_RETRY 1
//
// A behavioural W5300 slave answers every bus op after a random delay. For
// each socket and attempt it is told from a table whether that attempt should
// go wrong, and how:
//   kind 0: SSR stuck at 0x00 while waiting for INIT/UDP
//   kind 1: SSR stuck at 0x00 while waiting for LISTEN
//   kind 2: INIT/UDP match delivered exactly on the timeout cycle
//   kind 3: LISTEN match delivered exactly on the timeout cycle
//
// The expected write sequence and the final masks are derived from the same
// table.
// ---------------------------------------------------------------------------
module tb_w5300_socket_bank_conf;
    localparam int NI = 2;
`ifdef W5300_SOCK_KEEPALIVE_EN
    localparam bit KA = 1'b1;
`else
    localparam bit KA = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   rst_n;
    logic [NI-1:0]          enable;
    logic [NI-1:0]          start_op;
    logic [NI-1:0]          slave_op;
    logic [NI-1:0]          op_state;
    logic [NI-1:0][15:0]    rd_data;
    logic [NI-1:0][10:0]    addr;
    logic [NI-1:0][15:0]    wr_data;
    logic [NI-1:0]          done;
    logic [2:0]             ok0, fail0;
    logic [1:0]             ok1, fail1;

    assign op_state = slave_op | start_op;

    w5300_socket_bank_conf #(
        .NUM_SOCK(3), .MODE(0), .BASE_PORT(16'd7000), .TIMEOUT(16'd100), .MAX_RETRY(3)
    ) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable[0]), .op_state(op_state[0]),
        .rd_data(rd_data[0]), .addr(addr[0]), .wr_data(wr_data[0]), .done(done[0]),
        .ok_mask(ok0), .fail_mask(fail0)
    );

    w5300_socket_bank_conf #(
        .NUM_SOCK(2), .MODE(1), .BASE_PORT(16'hFFFF), .TIMEOUT(16'd12), .MAX_RETRY(1)
    ) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable[1]), .op_state(op_state[1]),
        .rd_data(rd_data[1]), .addr(addr[1]), .wr_data(wr_data[1]), .done(done[1]),
        .ok_mask(ok1), .fail_mask(fail1)
    );

    function automatic int p_ns(int i);   return (i == 0) ? 3 : 2;            endfunction
    function automatic int p_mode(int i); return (i == 0) ? 0 : 1;            endfunction
    function automatic int p_base(int i); return (i == 0) ? 7000 : 'hFFFF;    endfunction
    function automatic int p_tmo(int i);  return (i == 0) ? 100 : 12;         endfunction
    function automatic int p_mr(int i);   return (i == 0) ? 3 : 1;            endfunction

    int checks = 0;
    int errors = 0;

    // Per instance and socket: number of failing attempts, and their kinds.
    int n_bad    [NI][8];
    int bad_kind [NI][8][8];
    // Slave bookkeeping.
    int att      [NI][8];
    int last_cr  [NI][8];
    bit first_rd [NI];
    bit active   [NI];
    int cnt      [NI];
    logic [10:0] cur_addr [NI];
    logic [26:0] wlog  [NI][$];
    logic [26:0] exp_w [NI][$];
    logic [7:0]  exp_ok   [NI];
    logic [7:0]  exp_fail [NI];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [9:0] sreg(int s, int off);
        return 10'(32'h200 + s * 32'h40 + off);
    endfunction

    // The kind of trouble planned for socket s on its current attempt, or -1
    // when this attempt should succeed.
    function automatic int cur_kind(int i, int s);
        int a;
        a = att[i][s] - 1;
        if (a >= 0 && a < n_bad[i][s] && a < 8) return bad_kind[i][s][a];
        return -1;
    endfunction

    // Behavioural W5300: every new op gets an answer after a random delay.
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit fresh;
            int s, k, off;
            fresh = slave_op[i];
            slave_op[i] = 1'b0;
            rd_data[i] = 16'($urandom);
            if (!rst_n) begin
                active[i] = 1'b0;
                cur_addr[i] = '0;
            end else if (addr[i] == 11'h000) begin
                active[i] = 1'b0;
                cur_addr[i] = '0;
                // A stray strobe outside any bus op must be ignored.
                slave_op[i] = ($urandom_range(0, 7) == 0);
            end else begin
                s = (int'(addr[i][9:0]) - 'h200) / 'h40;
                off = int'(addr[i][5:0]);
                if (fresh || addr[i] != cur_addr[i]) begin
                    cur_addr[i] = addr[i];
                    active[i] = 1'b1;
                    cnt[i] = $urandom_range(0, 3);
                    if (!addr[i][10] && first_rd[i]) begin
                        first_rd[i] = 1'b0;
                        k = cur_kind(i, s);
                        if ((k == 2 && last_cr[i][s] == 1) || (k == 3 && last_cr[i][s] == 2))
                            cnt[i] = p_tmo(i);
                    end
                end
                if (active[i]) begin
                    if (cnt[i] == 0) begin
                        active[i] = 1'b0;
                        slave_op[i] = 1'b1;
                        if (addr[i][10]) begin
                            wlog[i].push_back({addr[i], wr_data[i]});
                            if (off == 'h02) begin
                                first_rd[i] = 1'b1;
                                if (wr_data[i] == 16'h0001) att[i][s]++;
                                last_cr[i][s] = int'(wr_data[i]);
                            end
                        end else begin
                            k = cur_kind(i, s);
                            if (last_cr[i][s] == 2)
                                rd_data[i][7:0] = (k == 1) ? 8'h00 : 8'h14;
                            else if (k == 0)
                                rd_data[i][7:0] = 8'h00;
                            else
                                rd_data[i][7:0] = (p_mode(i) == 0) ? 8'h13 : 8'h22;
                        end
                    end else begin
                        cnt[i]--;
                    end
                end
            end
        end
    end

    task automatic push_w(int i, logic [9:0] r, logic [15:0] d);
        exp_w[i].push_back({1'b1, r, d});
    endtask

    // Expected writes from the retry rules: every failing attempt ends in a
    // CLOSE, and a socket gets at most MAX_RETRY+1 attempts.
    task automatic build_expected(int i);
        int nbad;
        int k;
        logic [15:0] mr;
        exp_w[i].delete();
        exp_ok[i] = '0;
        exp_fail[i] = '0;
        mr = (p_mode(i) == 0) ? 16'h0001 : 16'h0002;
        for (int s = 0; s < p_ns(i); s++) begin
            nbad = (n_bad[i][s] < p_mr(i) + 1) ? n_bad[i][s] : p_mr(i) + 1;
            for (int a = 0; a <= nbad; a++) begin
                if (a == nbad && n_bad[i][s] > p_mr(i)) break;
                push_w(i, sreg(s, 'h00), mr);
                push_w(i, sreg(s, 'h0A), 16'(p_base(i) + s));
                if (KA && p_mode(i) == 0) push_w(i, sreg(s, 'h1A), 16'h0101);
                push_w(i, sreg(s, 'h02), 16'h0001);
                k = (a < nbad) ? bad_kind[i][s][a] : -1;
                if (p_mode(i) == 0 && k != 0 && k != 2) push_w(i, sreg(s, 'h02), 16'h0002);
                if (k >= 0) push_w(i, sreg(s, 'h02), 16'h0010);
            end
            if (n_bad[i][s] > p_mr(i)) exp_fail[i][s] = 1'b1;
            else                       exp_ok[i][s] = 1'b1;
        end
    endtask

    task automatic randomize_plan();
        for (int i = 0; i < NI; i++)
            for (int s = 0; s < 8; s++) begin
                n_bad[i][s] = $urandom_range(0, p_mr(i) + 2);
                for (int a = 0; a < 8; a++)
                    bad_kind[i][s][a] = (p_mode(i) == 0) ? $urandom_range(0, 3)
                                                          : 2 * $urandom_range(0, 1);
            end
    endtask

    task automatic reset_and_start();
        @(negedge clk);
        rst_n = 1'b0;
        enable = '0;
        start_op = '0;
        for (int i = 0; i < NI; i++) begin
            wlog[i].delete();
            first_rd[i] = 1'b0;
            for (int s = 0; s < 8; s++) begin
                att[i][s] = 0;
                last_cr[i][s] = 0;
            end
            build_expected(i);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        enable = '1;
        start_op = '1;
        @(negedge clk);
        enable = '0;
        start_op = '0;
        // A late enable pulse must not restart anything.
        repeat (3) @(negedge clk);
        enable = '1;
        @(negedge clk);
        enable = '0;
    endtask

    task automatic wait_and_compare(input int rnd);
        int c;
        c = 0;
        while (!(done[0] && done[1]) && c < 20000) begin
            @(negedge clk);
            c++;
        end
        check($sformatf("r%0d done_in_time", rnd), {30'd0, done}, 32'h3);
        repeat (4) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("r%0d i%0d write_count", rnd, i), wlog[i].size(), exp_w[i].size());
            for (int j = 0; j < exp_w[i].size() && j < wlog[i].size(); j++)
                check($sformatf("r%0d i%0d write%0d", rnd, i, j), wlog[i][j], exp_w[i][j]);
            check($sformatf("r%0d i%0d done_hold", rnd, i), done[i], 1'b1);
            check($sformatf("r%0d i%0d idle_addr", rnd, i), {addr[i], wr_data[i]}, 27'h0);
        end
        check($sformatf("r%0d ok_mask0", rnd), ok0, exp_ok[0][2:0]);
        check($sformatf("r%0d fail_mask0", rnd), fail0, exp_fail[0][2:0]);
        check($sformatf("r%0d ok_mask1", rnd), ok1, exp_ok[1][1:0]);
        check($sformatf("r%0d fail_mask1", rnd), fail1, exp_fail[1][1:0]);
        $display("round %0d: writes %0d/%0d ok %b/%b fail %b/%b", rnd,
                 wlog[0].size(), wlog[1].size(), ok0, ok1, fail0, fail1);
    endtask

    task automatic check_cleared(input string tag);
        for (int i = 0; i < NI; i++) begin
            check($sformatf("%s i%0d done", tag, i), done[i], 1'b0);
            check($sformatf("%s i%0d bus", tag, i), {addr[i], wr_data[i]}, 27'h0);
        end
        check({tag, " masks"}, {ok0, fail0, ok1, fail1}, 10'h0);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        enable = '0;
        start_op = '0;
        slave_op = '0;
        #1;
        check_cleared("reset");

        // Round 0: directed corner cases. Socket 0 of inst 0 never opens and
        // burns all four attempts. Socket 1 sees a match on the timeout cycle.
        // The UDP instance does the same on socket 0.
        randomize_plan();
        n_bad[0][0] = 4;
        for (int a = 0; a < 8; a++) bad_kind[0][0][a] = 0;
        n_bad[0][1] = 1;
        bad_kind[0][1][0] = 2;
        n_bad[0][2] = 0;
        n_bad[1][0] = 1;
        bad_kind[1][0][0] = 2;
        n_bad[1][1] = 0;
        reset_and_start();
        wait_and_compare(0);

        for (int r = 1; r <= 3; r++) begin
            randomize_plan();
            reset_and_start();
            wait_and_compare(r);
        end

        // Pull reset asynchronously while socket 1 of inst 0 polls for LISTEN.
        randomize_plan();
        n_bad[0][0] = 0;
        n_bad[0][1] = 0;
        reset_and_start();
        c = 0;
        while (!(addr[0] == {1'b0, sreg(1, 'h08)} && last_cr[0][1] == 2) && c < 5000) begin
            @(negedge clk);
            c++;
        end
        check("reach_poll_listen_s1", {addr[0], 1'b0}, {1'b0, sreg(1, 'h08), 1'b0});
        #2 rst_n = 1'b0;
        #1;
        check_cleared("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("after_midreset");

        // The next run must start again from socket 0.
        randomize_plan();
        reset_and_start();
        wait_and_compare(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
